// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises the instruction-fetch port and the load/store port
// onto one unified memory port. Data requests win by default; a saturating
// starvation counter forces a fetch grant after STARVE_MAX consecutive data
// grants made while fetch was waiting.
//
// Handshake: a requester raises *_req and holds it (with stable command
// fields) until its *_ack pulses for one cycle; the ack cycle is an IDLE
// bubble. Towards memory, m_req rises on the grant edge and stays high with
// a stable command until m_ready is sampled high; m_ready is ignored while
// no access is outstanding.
module mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  input  logic              m_ready,
  output logic [1:0]        dbg_state,
  output logic [3:0]        dbg_starve_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic                kill_q, kill_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [3:0]          m_be_q, m_be_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [31:0]         m_wdata_q, m_wdata_d;
  logic [31:0]         i_rdata_q, i_rdata_d;
  logic                i_ack_q, i_ack_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                d_ack_q, d_ack_d;

  logic d_elig, i_elig, grant_d, grant_i;

  // Eligibility excludes a requester in its own ack cycle and a fetch being redirected.
  always_comb begin
    d_elig  = d_req & ~d_ack_q;
    i_elig  = i_req & ~i_ack_q & ~i_flush;
    grant_d = d_elig & (~i_elig | (starve_q != STARVE_LIM));
    grant_i = i_elig & ~grant_d;
  end

  // Next-state, command latch, completion capture and starvation bookkeeping.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    kill_d    = kill_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d   = D_BUSY;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_be_d    = d_be;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (!i_req)                      starve_d = 4'd0;
          else if (starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
        end else if (grant_i) begin
          state_d  = I_BUSY;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_be_d   = 4'hF;
          m_addr_d = i_addr;
          starve_d = 4'd0;
        end
      end
      I_BUSY: begin
        // A redirect cannot abort the memory access; it only discards the result.
        kill_d = kill_q | i_flush;
        if (m_ready) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          kill_d  = 1'b0;
          if (!(kill_q | i_flush)) begin
            i_ack_d   = 1'b1;
            i_rdata_d = m_rdata;
          end
        end
      end
      D_BUSY: begin
        if (m_ready) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          d_ack_d = 1'b1;
          if (!m_we_q) d_rdata_d = m_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears m_req at once so memory sees no stale access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      starve_q  <= 4'd0;
      kill_q    <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= 4'd0;
      m_addr_q  <= '0;
      m_wdata_q <= 32'd0;
      i_rdata_q <= 32'd0;
      i_ack_q   <= 1'b0;
      d_rdata_q <= 32'd0;
      d_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      kill_q    <= kill_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      i_ack_q   <= i_ack_d;
      d_rdata_q <= d_rdata_d;
      d_ack_q   <= d_ack_d;
    end
  end

  assign i_rdata        = i_rdata_q;
  assign i_ack          = i_ack_q;
  assign i_stall        = i_req & ~i_ack_q;
  assign d_rdata        = d_rdata_q;
  assign d_ack          = d_ack_q;
  assign d_stall        = d_req & ~d_ack_q;
  assign m_req          = m_req_q;
  assign m_we           = m_we_q;
  assign m_be           = m_be_q;
  assign m_addr         = m_addr_q;
  assign m_wdata        = m_wdata_q;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with hand-derived expectations,
// then randomized traffic checked cycle by cycle against a transaction-level
// reference model of the arbitration rules.
module tb_mem_arbiter;

  localparam int ADDR_W     = 10;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_req = 1'b0, i_flush = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [31:0]       i_rdata;
  logic              i_ack, i_stall;
  logic              d_req = 1'b0, d_we = 1'b0;
  logic [3:0]        d_be = 4'd0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [31:0]       d_wdata = 32'd0;
  logic [31:0]       d_rdata;
  logic              d_ack, d_stall;
  logic              m_req, m_we;
  logic [3:0]        m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata = 32'd0;
  logic              m_ready = 1'b0;
  logic [1:0]        dbg_state;
  logic [3:0]        dbg_starve_cnt;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_rdata(i_rdata), .i_ack(i_ack), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // owner: 0 = nobody holds memory, 1 = fetch, 2 = data
  int                mdl_owner;
  int                mdl_cnt;
  logic              mdl_kill;
  logic              mdl_m_req, mdl_m_we;
  logic [3:0]        mdl_m_be;
  logic [ADDR_W-1:0] mdl_m_addr;
  logic [31:0]       mdl_m_wdata, mdl_i_rdata, mdl_d_rdata;
  logic              mdl_i_ack, mdl_d_ack;
  logic              mdl_d_wants, mdl_i_wants;

  assign mdl_d_wants = d_req && !mdl_d_ack;
  assign mdl_i_wants = i_req && !mdl_i_ack && !i_flush;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_owner <= 0; mdl_cnt <= 0; mdl_kill <= 1'b0;
      mdl_m_req <= 1'b0; mdl_m_we <= 1'b0; mdl_m_be <= 4'd0; mdl_m_addr <= '0; mdl_m_wdata <= 32'd0;
      mdl_i_rdata <= 32'd0; mdl_d_rdata <= 32'd0; mdl_i_ack <= 1'b0; mdl_d_ack <= 1'b0;
    end else begin
      mdl_i_ack <= 1'b0;
      mdl_d_ack <= 1'b0;
      if (mdl_owner == 0) begin
        if (mdl_d_wants && (!mdl_i_wants || mdl_cnt < STARVE_MAX)) begin
          mdl_owner <= 2; mdl_m_req <= 1'b1;
          mdl_m_we <= d_we; mdl_m_be <= d_be; mdl_m_addr <= d_addr; mdl_m_wdata <= d_wdata;
          mdl_cnt <= i_req ? ((mdl_cnt + 1 > STARVE_MAX) ? STARVE_MAX : mdl_cnt + 1) : 0;
        end else if (mdl_i_wants) begin
          mdl_owner <= 1; mdl_m_req <= 1'b1;
          mdl_m_we <= 1'b0; mdl_m_be <= 4'hF; mdl_m_addr <= i_addr;
          mdl_cnt <= 0;
        end
      end else begin
        if (mdl_owner == 1 && i_flush) mdl_kill <= 1'b1;
        if (m_ready) begin
          mdl_owner <= 0;
          mdl_m_req <= 1'b0;
          if (mdl_owner == 1) begin
            mdl_kill <= 1'b0;
            if (!(mdl_kill || i_flush)) begin
              mdl_i_ack <= 1'b1; mdl_i_rdata <= m_rdata;
            end
          end else begin
            mdl_d_ack <= 1'b1;
            if (!mdl_m_we) mdl_d_rdata <= m_rdata;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    i_req = 1'b0; i_flush = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'd0; d_addr = '0; d_wdata = 32'd0;
    m_ready = 1'b0; m_rdata = 32'd0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    next_cycle(); next_cycle();
    checks++; if ({m_req, m_we, m_be, i_ack, d_ack} !== 7'd0) begin failures++; $display("FAIL reset_ctrl actual=%b expected=0", {m_req, m_we, m_be, i_ack, d_ack}); end
    checks++; if ({i_rdata, d_rdata} !== 64'd0) begin failures++; $display("FAIL reset_rdata actual=%h expected=0", {i_rdata, d_rdata}); end
    checks++; if ({dbg_state, dbg_starve_cnt} !== 6'd0) begin failures++; $display("FAIL reset_state actual=%h expected=0", {dbg_state, dbg_starve_cnt}); end
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_fetch_only();
    i_req = 1'b1; i_addr = 10'h040;
    next_cycle();
    checks++; if ({m_req, m_we, m_be, m_addr} !== {1'b1, 1'b0, 4'hF, 10'h040}) begin failures++; $display("FAIL fetch_cmd actual=%h expected=%h", {m_req, m_we, m_be, m_addr}, {1'b1, 1'b0, 4'hF, 10'h040}); end
    checks++; if (i_stall !== 1'b1) begin failures++; $display("FAIL fetch_stall_busy actual=%b expected=1", i_stall); end
    m_ready = 1'b1; m_rdata = 32'h2402000A;
    next_cycle();
    checks++; if ({i_ack, i_stall, m_req} !== 3'b100) begin failures++; $display("FAIL fetch_ack actual=%b expected=100", {i_ack, i_stall, m_req}); end
    checks++; if (i_rdata !== 32'h2402000A) begin failures++; $display("FAIL fetch_rdata actual=%h expected=2402000a", i_rdata); end
    i_req = 1'b0; m_ready = 1'b0;
    next_cycle();
    checks++; if ({i_ack, i_rdata} !== {1'b0, 32'h2402000A}) begin failures++; $display("FAIL fetch_hold actual=%h expected=%h", {i_ack, i_rdata}, {1'b0, 32'h2402000A}); end
  endtask

  task automatic test_simultaneous();
    i_req = 1'b1; i_addr = 10'h080;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h100;
    next_cycle();
    checks++; if ({dbg_state, m_addr, dbg_starve_cnt} !== {2'd2, 10'h100, 4'd1}) begin failures++; $display("FAIL simul_data_first actual=%h expected=%h", {dbg_state, m_addr, dbg_starve_cnt}, {2'd2, 10'h100, 4'd1}); end
    m_ready = 1'b1; m_rdata = 32'h11112222;
    next_cycle();
    checks++; if ({d_ack, i_ack, dbg_state, d_rdata} !== {2'b10, 2'd0, 32'h11112222}) begin failures++; $display("FAIL simul_d_ack actual=%h expected=%h", {d_ack, i_ack, dbg_state, d_rdata}, {2'b10, 2'd0, 32'h11112222}); end
    d_req = 1'b0; m_ready = 1'b0;
    next_cycle();
    checks++; if ({dbg_state, m_we, m_addr, dbg_starve_cnt} !== {2'd1, 1'b0, 10'h080, 4'd0}) begin failures++; $display("FAIL simul_fetch_next actual=%h expected=%h", {dbg_state, m_we, m_addr, dbg_starve_cnt}, {2'd1, 1'b0, 10'h080, 4'd0}); end
    m_ready = 1'b1; m_rdata = 32'h33334444;
    next_cycle();
    checks++; if ({i_ack, i_rdata} !== {1'b1, 32'h33334444}) begin failures++; $display("FAIL simul_i_ack actual=%h expected=%h", {i_ack, i_rdata}, {1'b1, 32'h33334444}); end
    i_req = 1'b0; m_ready = 1'b0;
    next_cycle();
  endtask

  // Fetch stays requested throughout; a redirect is signalled in each data-ack
  // bubble so that every following IDLE cycle sees both requesters eligible.
  task automatic test_starvation();
    i_req = 1'b1; i_addr = 10'h0C0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h300;
    for (int k = 0; k < STARVE_MAX; k++) begin
      next_cycle();
      checks++; if ({dbg_state, dbg_starve_cnt, m_addr} !== {2'd2, 4'(k + 1), 10'(10'h300 + k)}) begin failures++; $display("FAIL starve_data_grant%0d actual=%h expected=%h", k, {dbg_state, dbg_starve_cnt, m_addr}, {2'd2, 4'(k + 1), 10'(10'h300 + k)}); end
      m_ready = 1'b1; m_rdata = 32'hA5A50000 | k;
      next_cycle();
      checks++; if ({d_ack, i_ack, d_rdata} !== {2'b10, 32'hA5A50000 | k}) begin failures++; $display("FAIL starve_d_ack%0d actual=%h expected=%h", k, {d_ack, i_ack, d_rdata}, {2'b10, 32'hA5A50000 | k}); end
      m_ready = 1'b0; i_flush = 1'b1;
      next_cycle();
      checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL starve_bubble%0d actual=%0d expected=0", k, dbg_state); end
      i_flush = 1'b0; d_addr = 10'(10'h300 + k + 1);
    end
    next_cycle();
    checks++; if ({dbg_state, dbg_starve_cnt, m_addr, m_be} !== {2'd1, 4'd0, 10'h0C0, 4'hF}) begin failures++; $display("FAIL starve_fetch_grant actual=%h expected=%h", {dbg_state, dbg_starve_cnt, m_addr, m_be}, {2'd1, 4'd0, 10'h0C0, 4'hF}); end
    d_req = 1'b0; m_ready = 1'b1; m_rdata = 32'h0BADF00D;
    next_cycle();
    checks++; if ({i_ack, i_rdata} !== {1'b1, 32'h0BADF00D}) begin failures++; $display("FAIL starve_i_ack actual=%h expected=%h", {i_ack, i_rdata}, {1'b1, 32'h0BADF00D}); end
    i_req = 1'b0; m_ready = 1'b0;
    next_cycle();
  endtask

  task automatic test_write();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 10'h204; d_wdata = 32'hDEADBEEF;
    next_cycle();
    checks++; if ({m_req, m_we, m_be, m_addr, m_wdata} !== {1'b1, 1'b1, 4'b0011, 10'h204, 32'hDEADBEEF}) begin failures++; $display("FAIL write_cmd actual=%h expected=%h", {m_req, m_we, m_be, m_addr, m_wdata}, {1'b1, 1'b1, 4'b0011, 10'h204, 32'hDEADBEEF}); end
    d_we = 1'b0; d_be = 4'hC; d_addr = 10'h3FF; d_wdata = 32'h01234567;
    next_cycle();
    checks++; if ({m_req, m_we, m_be, m_addr, m_wdata} !== {1'b1, 1'b1, 4'b0011, 10'h204, 32'hDEADBEEF}) begin failures++; $display("FAIL write_stable actual=%h expected=%h", {m_req, m_we, m_be, m_addr, m_wdata}, {1'b1, 1'b1, 4'b0011, 10'h204, 32'hDEADBEEF}); end
    m_ready = 1'b1; m_rdata = 32'hFFFFFFFF;
    next_cycle();
    checks++; if ({d_ack, m_req, d_rdata} !== {2'b10, 32'hA5A50003}) begin failures++; $display("FAIL write_ack actual=%h expected=%h", {d_ack, m_req, d_rdata}, {2'b10, 32'hA5A50003}); end
    d_req = 1'b0; m_ready = 1'b0;
    next_cycle();
  endtask

  task automatic test_flush();
    i_req = 1'b1; i_addr = 10'h100;
    next_cycle();
    checks++; if ({dbg_state, m_req} !== {2'd1, 1'b1}) begin failures++; $display("FAIL flush_grant actual=%b expected=011", {dbg_state, m_req}); end
    i_flush = 1'b1; i_req = 1'b0;
    next_cycle();
    i_flush = 1'b0;
    checks++; if (m_req !== 1'b1) begin failures++; $display("FAIL flush_mreq_held1 actual=%b expected=1", m_req); end
    next_cycle();
    checks++; if (m_req !== 1'b1) begin failures++; $display("FAIL flush_mreq_held2 actual=%b expected=1", m_req); end
    m_ready = 1'b1; m_rdata = 32'h77778888;
    next_cycle();
    checks++; if ({i_ack, m_req, dbg_state, i_rdata} !== {2'b00, 2'd0, 32'h0BADF00D}) begin failures++; $display("FAIL flush_no_ack actual=%h expected=%h", {i_ack, m_req, dbg_state, i_rdata}, {2'b00, 2'd0, 32'h0BADF00D}); end
    m_ready = 1'b0; i_req = 1'b1; i_addr = 10'h144;
    next_cycle();
    checks++; if ({dbg_state, m_addr} !== {2'd1, 10'h144}) begin failures++; $display("FAIL flush_refetch_grant actual=%h expected=%h", {dbg_state, m_addr}, {2'd1, 10'h144}); end
    m_ready = 1'b1; m_rdata = 32'h00000055;
    next_cycle();
    checks++; if ({i_ack, i_rdata} !== {1'b1, 32'h00000055}) begin failures++; $display("FAIL flush_refetch_ack actual=%h expected=%h", {i_ack, i_rdata}, {1'b1, 32'h00000055}); end
    i_req = 1'b0; m_ready = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_busy();
    i_req = 1'b1; i_addr = 10'h0A0;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 10'h010; d_wdata = 32'hCAFEF00D;
    next_cycle();
    checks++; if ({dbg_state, m_req, m_we, dbg_starve_cnt} !== {2'd2, 2'b11, 4'd1}) begin failures++; $display("FAIL rstbusy_pre actual=%h expected=%h", {dbg_state, m_req, m_we, dbg_starve_cnt}, {2'd2, 2'b11, 4'd1}); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({m_req, m_we, i_ack, d_ack} !== 4'd0) begin failures++; $display("FAIL rstbusy_async actual=%b expected=0000", {m_req, m_we, i_ack, d_ack}); end
    drive_idle();
    next_cycle(); next_cycle();
    rst = 1'b1;
    checks++; if ({dbg_state, dbg_starve_cnt} !== 6'd0) begin failures++; $display("FAIL rstbusy_state actual=%h expected=0", {dbg_state, dbg_starve_cnt}); end
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020;
    next_cycle();
    checks++; if ({dbg_state, m_req, m_we, m_addr} !== {2'd2, 2'b10, 10'h020}) begin failures++; $display("FAIL rstbusy_regrant actual=%h expected=%h", {dbg_state, m_req, m_we, m_addr}, {2'd2, 2'b10, 10'h020}); end
    m_ready = 1'b1; m_rdata = 32'h13579BDF;
    next_cycle();
    checks++; if ({d_ack, d_rdata} !== {1'b1, 32'h13579BDF}) begin failures++; $display("FAIL rstbusy_ack actual=%h expected=%h", {d_ack, d_rdata}, {1'b1, 32'h13579BDF}); end
    drive_idle();
    next_cycle();
  endtask

  task automatic test_random(input int n_cycles);
    logic [115:0] act_vec, exp_vec;
    int bad = 0;
    for (int c = 0; c < n_cycles; c++) begin
      next_cycle();
      act_vec = {m_req, m_we, m_be, m_addr, m_wdata, i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall};
      exp_vec = {mdl_m_req, mdl_m_we, mdl_m_be, mdl_m_addr, mdl_m_wdata, mdl_i_ack, mdl_i_rdata,
                 i_req & ~mdl_i_ack, mdl_d_ack, mdl_d_rdata, d_req & ~mdl_d_ack};
      checks++;
      if (act_vec !== exp_vec || dbg_state !== 2'(mdl_owner) || dbg_starve_cnt !== 4'(mdl_cnt)) begin
        failures++;
        if (bad < 5) $display("FAIL random_cycle%0d actual=%h/%0d/%0d expected=%h/%0d/%0d",
                              c, act_vec, dbg_state, dbg_starve_cnt, exp_vec, mdl_owner, mdl_cnt);
        bad++;
      end
      // fetch requester
      if (i_ack) i_req = 1'b0;
      else if (!i_req && $urandom_range(0, 1) == 1) begin i_req = 1'b1; i_addr = 10'($urandom_range(0, 1023)); end
      i_flush = ($urandom_range(0, 7) == 0);
      if (i_flush && $urandom_range(0, 1) == 1) i_req = 1'b0;
      // data requester
      if (d_ack) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(0, 15));
        d_addr = 10'($urandom_range(0, 1023)); d_wdata = $urandom;
      end
      // memory
      m_ready = ($urandom_range(0, 2) == 0);
      m_rdata = $urandom;
    end
    drive_idle();
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_write();
    test_flush();
    test_reset_busy();
    test_random(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction-fetch port (IF stage) and the load/store port (MEM stage) of the pipelined core, for builds where IM and DM are merged into one unified memory. It serialises both requesters onto one memory port with a variable-latency ready handshake and returns read data and a one-cycle acknowledge to the winner. Data requests win by default, and a bounded starvation counter guarantees forward progress for fetch. The stall outputs feed hazard_detect (PCWr/IFIDWr gating).

## Interface
- ADDR_W, 10, byte address width; matches PC[9:0] and ALU result [9:0].
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits; range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch address.
- i_flush  in  1  cancel the current or pending fetch (branch/jump redirect).
- i_rdata  out  32  fetched word; registered.
- i_ack  out  1  one-cycle pulse when i_rdata is valid.
- i_stall  out  1  comb: i_req & ~i_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  4  byte enables for writes.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  32  write data.
- d_rdata  out  32  load data; registered.
- d_ack  out  1  one-cycle pulse when the access has completed.
- d_stall  out  1  comb: d_req & ~d_ack.
- m_req  out  1  memory request; held high until m_ready.
- m_we, m_be, m_addr, m_wdata  out  1/4/ADDR_W/32  memory command; stable while m_req is high.
- m_rdata  in  32  memory read data; valid when m_ready is high.
- m_ready  in  1  memory completion strobe.

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY. On reset the FSM is in IDLE. All registered outputs are 0, starve_cnt = 0, and m_req drops immediately (asynchronously).
- In IDLE, the eligible requesters are:
  - d_req when d_ack = 0;
  - i_req when i_ack = 0 and i_flush = 0.
- Grant rules in IDLE:
  - Only one requester is eligible: that requester is granted.
  - Both are eligible and starve_cnt < STARVE_MAX: data is granted.
  - Both are eligible and starve_cnt == STARVE_MAX: fetch is granted.
- On grant:
  - Latch the command into the m_* registers and set m_req = 1.
  - For a fetch grant, force m_we = 0 and m_be = 4'hF.
  - Go to I_BUSY or D_BUSY.
- starve_cnt update, applied on every grant:
  - Data grant with i_req high: starve_cnt + 1, saturating at STARVE_MAX.
  - Fetch grant, or data grant with i_req low: starve_cnt = 0.
- In BUSY, when m_ready is sampled high:
  - m_req goes to 0.
  - For reads, m_rdata is captured into i_rdata or d_rdata.
  - The matching ack pulses for one cycle.
  - The FSM returns to IDLE.
  - The rdata registers hold their value until the next capture.
- i_flush in I_BUSY:
  - Set a sticky kill flag.
  - The memory transaction still completes; m_req is never withdrawn mid-access.
  - On m_ready: i_ack is suppressed, i_rdata is not updated, and the kill flag clears.
- i_flush in IDLE only blocks fetch eligibility for that cycle.
- Writes:
  - d_ack pulses on m_ready.
  - d_rdata is unchanged.
  - m_be is passed through from d_be.
- Request-input changes are ignored while in BUSY. The latched command is authoritative.

## Timing
- A request sampled at edge t in IDLE gives m_req = 1 after edge t.
- m_ready sampled at edge t+k gives ack = 1 and rdata valid after edge t+k. The FSM is in IDLE in that same cycle.
- Minimum request-to-ack latency is 2 cycles (m_ready high in the first BUSY cycle).
- The requester deasserts req in the cycle where ack is high. That cycle is the bubble, so back-to-back grants are spaced by at least one IDLE cycle.
- m_ready is ignored in IDLE.
- Assertion of rst is asynchronous. Deassertion is synchronous to clk by the system reset synchroniser.

## Test plan
- Fetch only: i_addr = 0x040 and m_ready 1 cycle after m_req, with m_rdata = 0x2402000A. Required: m_addr = 0x040, m_we = 0, i_ack 2 cycles after i_req, i_rdata = 0x2402000A, i_stall low on the ack cycle.
- Simultaneous i_req and d_req with a read at 0x100: D_BUSY first, d_ack, then I_BUSY. i_ack arrives after d_ack and no earlier than 2 cycles later.
- Starvation with STARVE_MAX = 4 and d_req re-asserted every IDLE cycle while i_req is held: exactly 4 data grants, then 1 fetch grant, then starve_cnt = 0.
- Write with d_we = 1, d_be = 4'b0011, d_wdata = 0xDEADBEEF, d_addr = 0x204. Required: m_be = 0011 and m_wdata = 0xDEADBEEF stable until m_ready, d_ack pulses, d_rdata unchanged.
- i_flush in I_BUSY with m_ready 3 cycles later: m_req stays high until m_ready, no i_ack, i_rdata keeps its old value, a later fetch completes normally.
- rst low in D_BUSY: m_req, m_we and acks are 0 immediately. After release the FSM is in IDLE, starve_cnt = 0, and the next d_req is granted cleanly.
